// File: rtl/packet_split_router.sv
// Clocked 1-to-2 packet demultiplexer: each accepted packet is queued on output R0 or R1
// according to one route bit, with an independent FIFO and delivered-packet counter per output.
module packet_split_router #(
  parameter int WIDTH_packet = 14,
  parameter int SEL_BIT      = 13,
  parameter int DEPTH        = 2,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    L_valid,
  output logic                    L_ready,
  input  logic [WIDTH_packet-1:0] L_data,
  output logic                    R0_valid,
  input  logic                    R0_ready,
  output logic [WIDTH_packet-1:0] R0_data,
  output logic                    R1_valid,
  input  logic                    R1_ready,
  output logic [WIDTH_packet-1:0] R1_data,
  output logic [CNT_W-1:0]        R0_count,
  output logic [CNT_W-1:0]        R1_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                         sel;
  logic [1:0]                   full;
  logic [1:0]                   empty;
  logic [1:0]                   push;
  logic [1:0]                   pop;
  logic [1:0]                   out_ready;
  logic [1:0][WIDTH_packet-1:0] head;
  logic [1:0][CNT_W-1:0]        count;

  assign sel       = L_data[SEL_BIT];
  assign out_ready = {R1_ready, R0_ready};

  // Accept depends only on the addressed FIFO's registered full flag, so one
  // stalled output never blocks traffic headed to the other.
  assign L_ready = sel ? ~full[1] : ~full[0];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH_packet-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [OCC_W-1:0]        occ;
    logic [CNT_W-1:0]        cnt;

    assign push[g]  = L_valid & L_ready & (sel == 1'(g));
    assign pop[g]   = ~empty[g] & out_ready[g];
    assign full[g]  = (occ == OCC_W'(DEPTH));
    assign empty[g] = (occ == '0);
    assign head[g]  = mem[rd_ptr];
    assign count[g] = cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the storage is reset too, because the head
    // entry is visible on Rn_data and must read as zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
        cnt    <= '0;
      end else begin
        if (push[g]) begin
          mem[wr_ptr] <= L_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop[g]) begin
          rd_ptr <= rd_ptr + 1'b1;
          cnt    <= cnt + 1'b1;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({push[g], pop[g]})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end
    end
  end

  assign R0_valid = ~empty[0];
  assign R1_valid = ~empty[1];
  assign R0_data  = head[0];
  assign R1_data  = head[1];
  assign R0_count = count[0];
  assign R1_count = count[1];

endmodule
